// File: rtl/mipi_csi_pkg.sv
// Shared types and helpers for the CSI-2 receive lane path.
// Lane-count codes, deskew FSM states and the tap width used by the deskew stage.
package mipi_csi_pkg;

   typedef enum logic [2:0] {
      IDLE,
      ALIGN,
      STREAM,
      DRAIN,
      ERROR
   } deskew_state_e;

   localparam logic [1:0] LANES_1 = 2'd0;
   localparam logic [1:0] LANES_2 = 2'd1;
   localparam logic [1:0] LANES_4 = 2'd2;
   localparam logic [1:0] LANES_8 = 2'd3;

   // Tap/arrival width covers the widest legal skew window (MAX_SKEW up to 7).
   localparam int MAX_SKEW_LIMIT = 7;
   localparam int SKEW_W         = $clog2(MAX_SKEW_LIMIT + 1);

   function automatic int lane_count(input logic [1:0] code, input int mipi_lanes);
      int n;
      n = 1 << code;
      return (n > mipi_lanes) ? mipi_lanes : n;
   endfunction

endpackage

// File: rtl/mipi_rx_lane_delay.sv
// Per-lane byte/valid delay line with a registered tap mux.
// The tapped valid is exported combinationally so the FSM can gate the same-cycle output load.
module mipi_rx_lane_delay
   import mipi_csi_pkg::*;
#(
   parameter int MAX_SKEW = 4
) (
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic [7:0]        byte_i,
   input  logic              valid_i,
   input  logic [SKEW_W-1:0] tap_i,
   input  logic              emit_i,
   output logic              tap_valid_o,
   output logic [7:0]        dly_byte_o
);

   logic [7:0]        sr [MAX_SKEW+1];
   logic [MAX_SKEW:0] sr_v;
   logic [7:0]        tap_byte;

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         for (int k = 0; k <= MAX_SKEW; k++) sr[k] <= 8'h00;
         sr_v       <= '0;
         dly_byte_o <= 8'h00;
      end else begin
         sr[0] <= byte_i;
         for (int k = 1; k <= MAX_SKEW; k++) sr[k] <= sr[k-1];
         sr_v       <= {sr_v[MAX_SKEW-1:0], valid_i};
         dly_byte_o <= emit_i ? tap_byte : 8'h00;
      end
   end

   always_comb begin
      tap_byte    = 8'h00;
      tap_valid_o = 1'b0;
      for (int k = 0; k <= MAX_SKEW; k++) begin
         if (tap_i == SKEW_W'(k)) begin
            tap_byte    = sr[k];
            tap_valid_o = sr_v[k];
         end
      end
   end

endmodule

// File: rtl/mipi_rx_lane_deskew.sv
// N-lane deskew stage: measures per-lane arrival, then taps each delay line to realign words.
//   state  | meaning
//   IDLE   | wait for first active valid; lane count latched here
//   ALIGN  | record arrival offsets of remaining lanes within the skew window
//   STREAM | emit aligned words while every tapped valid is high
//   DRAIN  | packet ended; wait for all active raw valids low
//   ERROR  | skew or early drop; one error pulse, wait for all valids low
module mipi_rx_lane_deskew
   import mipi_csi_pkg::*;
#(
   parameter int MIPI_LANES = 4,
   parameter int MAX_SKEW   = 4
) (
   input  logic                    clk_i,
   input  logic                    reset_i,
   input  logic [1:0]              active_lanes_i,
   input  logic [MIPI_LANES-1:0]   bytes_valid_i,
   input  logic [8*MIPI_LANES-1:0] byte_i,
   output logic                    lane_valid_o,
   output logic [8*MIPI_LANES-1:0] lane_byte_o,
   output logic                    skew_err_o
);

   deskew_state_e state_q, state_d;

   logic [SKEW_W-1:0]                  cnt_q, cnt_d;
   logic [MIPI_LANES-1:0]              act_q, act_d, act_in, act;
   logic [MIPI_LANES-1:0]              arrived_q, arrived_d;
   logic [MIPI_LANES-1:0][SKEW_W-1:0]  arrival_q, arrival_d;
   logic [MIPI_LANES-1:0][SKEW_W-1:0]  tap_q, tap_d;
   logic [MIPI_LANES-1:0]              vld, fresh, tv;
   logic                               all_tv, emit, err_d;
   int                                 lane_n;

   always_comb begin
      lane_n = lane_count(active_lanes_i, MIPI_LANES);
      for (int l = 0; l < MIPI_LANES; l++) act_in[l] = (l < lane_n);
   end

   // The lane count is only live from the input while idle; afterwards the latched copy rules.
   assign act    = (state_q == IDLE) ? act_in : act_q;
   assign vld    = bytes_valid_i & act;
   assign fresh  = vld & ~arrived_q;
   assign all_tv = &(tv | ~act);
   assign emit   = (state_q == STREAM) && all_tv;

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         act_q        <= '0;
         arrived_q    <= '0;
         arrival_q    <= '0;
         tap_q        <= '0;
         lane_valid_o <= 1'b0;
         skew_err_o   <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         act_q        <= act_d;
         arrived_q    <= arrived_d;
         arrival_q    <= arrival_d;
         tap_q        <= tap_d;
         lane_valid_o <= emit;
         skew_err_o   <= err_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      act_d     = act_q;
      arrived_d = arrived_q;
      arrival_d = arrival_q;
      tap_d     = tap_q;
      err_d     = 1'b0;
      case (state_q)
         IDLE: begin
            act_d = act_in;
            cnt_d = '0;
            if (|vld) begin
               arrived_d = vld;
               arrival_d = '0;
               cnt_d     = SKEW_W'(1);
               if (vld == act) begin
                  state_d = STREAM;
                  tap_d   = '0;
               end else begin
                  state_d = ALIGN;
               end
            end
         end
         ALIGN: begin
            arrived_d = arrived_q | fresh;
            for (int l = 0; l < MIPI_LANES; l++)
               if (fresh[l]) arrival_d[l] = cnt_q;
            if (|(arrived_q & ~vld)) begin
               state_d = ERROR;
               err_d   = 1'b1;
            end else if (arrived_d == act) begin
               // Lanes completing now arrived at cnt, which is therefore the max arrival.
               state_d = STREAM;
               for (int l = 0; l < MIPI_LANES; l++)
                  tap_d[l] = act[l] ? (cnt_q - arrival_d[l]) : '0;
            end else if (cnt_q == SKEW_W'(MAX_SKEW)) begin
               state_d = ERROR;
               err_d   = 1'b1;
            end else begin
               cnt_d = cnt_q + SKEW_W'(1);
            end
         end
         STREAM: begin
            if (!all_tv) state_d = DRAIN;
         end
         DRAIN, ERROR: begin
            if (!(|vld)) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   for (genvar l = 0; l < MIPI_LANES; l++) begin : g_lane
      mipi_rx_lane_delay #(
         .MAX_SKEW (MAX_SKEW)
      ) u_delay (
         .clk_i       (clk_i),
         .reset_i     (reset_i),
         .byte_i      (byte_i[8*l +: 8]),
         .valid_i     (bytes_valid_i[l]),
         .tap_i       (tap_q[l]),
         .emit_i      (emit & act[l]),
         .tap_valid_o (tv[l]),
         .dly_byte_o  (lane_byte_o[8*l +: 8])
      );
   end

endmodule

// File: tb/tb_mipi_rx_lane_deskew.sv
// Directed bench for the lane deskew stage with a word scoreboard.
module tb_mipi_rx_lane_deskew;

   localparam int LANES = 4;

   logic               clk_i = 1'b0;
   logic               reset_i;
   logic [1:0]         active_lanes_i;
   logic [LANES-1:0]   bytes_valid_i;
   logic [8*LANES-1:0] byte_i;
   logic               lane_valid_o;
   logic [8*LANES-1:0] lane_byte_o;
   logic               skew_err_o;

   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          rise_cyc = -1;
   int          fall_cyc = -1;
   int          rise_cnt = 0;
   int          err_pulses = 0;
   int          base = 0;
   logic        prev_v = 1'b0;
   logic [31:0] sb [$];

   mipi_rx_lane_deskew #(
      .MIPI_LANES (LANES),
      .MAX_SKEW   (4)
   ) dut (
      .clk_i          (clk_i),
      .reset_i        (reset_i),
      .active_lanes_i (active_lanes_i),
      .bytes_valid_i  (bytes_valid_i),
      .byte_i         (byte_i),
      .lane_valid_o   (lane_valid_o),
      .lane_byte_o    (lane_byte_o),
      .skew_err_o     (skew_err_o)
   );

   always #5 clk_i = ~clk_i;

   always @(posedge clk_i) cyc <= cyc + 1;

   task automatic chk(input string tag, input longint obs, input longint exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] pat(input int l, input int k);
      return 8'(base + (l + 1) * 'h11 + k);
   endfunction

   always @(negedge clk_i) begin
      logic [31:0] exp_w;
      if (lane_valid_o && !prev_v) begin
         rise_cyc = cyc;
         rise_cnt++;
      end
      if (!lane_valid_o && prev_v) fall_cyc = cyc;
      prev_v = lane_valid_o;
      if (lane_valid_o) begin
         if (sb.size() == 0) begin
            chk("sb_extra_word", longint'(lane_byte_o), -1);
         end else begin
            exp_w = sb.pop_front();
            chk("sb_word", longint'(lane_byte_o), longint'(exp_w));
         end
      end
      if (skew_err_o) begin
         err_pulses++;
         chk("err_with_valid", longint'(lane_valid_o), 0);
      end
   end

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk_i);
         #1;
         bytes_valid_i = '0;
      end
   endtask

   // One lead idle cycle to load the lane code, then per-lane windows [off, off+len).
   task automatic drive_pkt(input int off[4], input int len[4], input logic [1:0] code,
                            input bit expect_out, output int t0);
      int          n, span, nwords;
      logic [31:0] w;
      n = 1 << code;
      if (n > LANES) n = LANES;
      span   = 0;
      nwords = 1000;
      for (int l = 0; l < n; l++) begin
         if (off[l] + len[l] > span) span = off[l] + len[l];
         if (len[l] < nwords) nwords = len[l];
      end
      if (expect_out) begin
         for (int k = 0; k < nwords; k++) begin
            w = '0;
            for (int l = 0; l < n; l++) w[8*l +: 8] = pat(l, k);
            sb.push_back(w);
         end
      end
      @(posedge clk_i);
      #1;
      active_lanes_i = code;
      bytes_valid_i  = '0;
      t0 = 0;
      for (int c = 0; c < span; c++) begin
         @(posedge clk_i);
         #1;
         if (c == 0) t0 = cyc;
         for (int l = 0; l < LANES; l++) begin
            if (l < n) begin
               bytes_valid_i[l]  = (c >= off[l]) && (c < off[l] + len[l]);
               byte_i[8*l +: 8]  = bytes_valid_i[l] ? pat(l, c - off[l]) : 8'($urandom);
            end else begin
               bytes_valid_i[l]  = 1'($urandom_range(0, 1));
               byte_i[8*l +: 8]  = 8'($urandom);
            end
         end
      end
      @(posedge clk_i);
      #1;
      bytes_valid_i = '0;
   endtask

   initial begin
      int t0, rc, ep;
      logic [31:0] w;
      reset_i        = 1'b1;
      active_lanes_i = 2'd2;
      bytes_valid_i  = '0;
      byte_i         = '0;
      repeat (2) @(posedge clk_i);
      #1;
      reset_i = 1'b0;
      @(negedge clk_i);
      chk("reset_valid", longint'(lane_valid_o), 0);
      chk("reset_byte", longint'(lane_byte_o), 0);
      chk("reset_err", longint'(skew_err_o), 0);
      idle(3);

      // zero skew, 4 lanes
      base = 0;
      drive_pkt('{0, 0, 0, 0}, '{6, 6, 6, 6}, 2'd2, 1'b1, t0);
      idle(6);
      chk("zero_rise_latency", rise_cyc - t0, 2);
      chk("zero_fall_after_inputs", fall_cyc - (t0 + 6), 2);
      chk("zero_sb_empty", sb.size(), 0);

      // skew 0,2,1,3 inside the window
      base = 'h40;
      drive_pkt('{0, 2, 1, 3}, '{6, 6, 6, 6}, 2'd2, 1'b1, t0);
      idle(8);
      chk("skew_rise_latency", rise_cyc - t0, 5);
      chk("skew_fall", fall_cyc - t0, 11);
      chk("skew_sb_empty", sb.size(), 0);

      // lane 3 beyond the window
      rc = rise_cnt;
      ep = err_pulses;
      base = 'h60;
      drive_pkt('{0, 0, 0, 5}, '{8, 8, 8, 3}, 2'd2, 1'b0, t0);
      idle(6);
      chk("ovf_err_pulses", err_pulses - ep, 1);
      chk("ovf_no_valid", rise_cnt - rc, 0);
      chk("ovf_sb_empty", sb.size(), 0);

      // two active lanes, lanes 2-3 random
      base = 'h80;
      drive_pkt('{0, 1, 0, 0}, '{5, 5, 0, 0}, 2'd1, 1'b1, t0);
      idle(8);
      chk("reduced_rise_latency", rise_cyc - t0, 3);
      chk("reduced_fall", fall_cyc - t0, 8);
      chk("reduced_sb_empty", sb.size(), 0);

      // lane 1 drops early; code 3 clamps to 4 lanes
      base = 'hA0;
      drive_pkt('{0, 0, 0, 0}, '{8, 5, 8, 8}, 2'd3, 1'b1, t0);
      idle(6);
      chk("drop_fall", fall_cyc - t0, 7);
      chk("drop_sb_empty", sb.size(), 0);

      base = 'hC0;
      drive_pkt('{1, 0, 0, 2}, '{4, 4, 4, 4}, 2'd2, 1'b1, t0);
      idle(8);
      chk("after_drop_rise", rise_cyc - t0, 4);
      chk("after_drop_sb_empty", sb.size(), 0);

      // reset while streaming: only the first two words get out
      base = 'hE0;
      active_lanes_i = 2'd2;
      for (int k = 0; k < 2; k++) begin
         for (int l = 0; l < LANES; l++) w[8*l +: 8] = pat(l, k);
         sb.push_back(w);
      end
      for (int c = 0; c < 4; c++) begin
         @(posedge clk_i);
         #1;
         if (c == 0) t0 = cyc;
         bytes_valid_i = '1;
         for (int l = 0; l < LANES; l++) byte_i[8*l +: 8] = pat(l, c);
         reset_i = (c == 3);
      end
      @(posedge clk_i);
      #1;
      reset_i       = 1'b0;
      bytes_valid_i = '0;
      @(negedge clk_i);
      chk("rst_mid_valid", longint'(lane_valid_o), 0);
      chk("rst_mid_byte", longint'(lane_byte_o), 0);
      chk("rst_mid_err", longint'(skew_err_o), 0);
      idle(3);
      chk("rst_sb_empty", sb.size(), 0);

      base = 'h05;
      drive_pkt('{0, 0, 0, 0}, '{3, 3, 3, 3}, 2'd2, 1'b1, t0);
      idle(6);
      chk("post_rst_rise", rise_cyc - t0, 2);
      chk("post_rst_sb_empty", sb.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mipi_rx_lane_deskew.md
# mipi_rx_lane_deskew

Parametrised N-lane deskew stage for the MIPI CSI-2 receive path. It sits between the per-lane byte aligners and the packet decoder, in the `mipi_byte_clock` domain. It replaces the fixed 4-lane aligner with:
- a configurable lane count (1–8 lanes);
- runtime selection of the active lane count;
- a bounded, measured skew window;
- explicit skew-error reporting.

## Interface
Parameters:
- `MIPI_LANES`, 4, number of physical lanes; legal values 1, 2, 4, 8.
- `MAX_SKEW`, 4, largest tolerated arrival spread in byte-clock cycles; legal range 1–7.

Ports:
- `clk_i`  in  1  byte clock.
- `reset_i`  in  1  reset. One clock; reset is synchronous and active-high.
- `active_lanes_i`  in  2  active lane count code: 0=1, 1=2, 2=4, 3=8. Active lanes are always lanes 0..N-1. A code requesting more than `MIPI_LANES` lanes is clamped to `MIPI_LANES`.
- `bytes_valid_i`  in  MIPI_LANES  per-lane valid from the byte aligners.
- `byte_i`  in  8*MIPI_LANES  per-lane bytes; lane l occupies bits [8l+7:8l].
- `lane_valid_o`  out  1  deskewed word valid.
- `lane_byte_o`  out  8*MIPI_LANES  deskewed word; bytes of inactive lanes are forced to 0.
- `skew_err_o`  out  1  single-cycle pulse when alignment fails.

## Operation
- States: IDLE, ALIGN, STREAM, DRAIN, ERROR.
- `active_lanes_i` is sampled only in IDLE. The decoded lane count N is held until the block returns to IDLE.
- Delay line, every cycle and in every state:
  - `sr[l][0] <= byte_i[l]`, `sr[l][k] <= sr[l][k-1]`, for k = 1..MAX_SKEW.
  - Per-lane delayed valid bits are shifted the same way.
- IDLE:
  - Arrival counter `cnt` is held at 0.
  - On the first cycle any active lane has valid high: every active lane with valid high records arrival 0, and `cnt` becomes 1.
  - If all N lanes are high on that cycle → STREAM. Otherwise → ALIGN.
- ALIGN:
  - Each not-yet-arrived active lane whose valid is high records arrival = `cnt`.
  - When all N lanes have arrived → STREAM. On entry, tap[l] = max_arrival − arrival[l].
  - If `cnt` == MAX_SKEW and lanes are still missing → ERROR.
  - If an already-arrived lane drops valid before alignment completes → ERROR.
  - Otherwise `cnt` increments.
- STREAM:
  - `lane_byte_o[l] <= sr[l][tap[l]]`.
  - `lane_valid_o` <= AND of the tapped delayed valids over the active lanes.
  - On the first cycle that AND is 0: `lane_valid_o` falls and the state → DRAIN. The partial word is not emitted.
- DRAIN: wait until all active raw valids are low → IDLE.
- ERROR:
  - `skew_err_o` pulses high on the cycle after entry.
  - Wait until all active raw valids are low → IDLE.
  - `lane_valid_o` stays 0 throughout.
- Taps are 0..MAX_SKEW and therefore always fit within the delay line.
- Valid bits on inactive lanes are ignored in every state.

## Timing
- Reset values: `lane_valid_o`=0, `lane_byte_o`=0, `skew_err_o`=0, state IDLE, all taps and arrivals 0, delay line cleared.
- Reset mid-packet: the block is in IDLE on the next cycle, with no output and no error pulse.
- Latency: the last-arriving lane's first byte, presented at cycle t, appears on `lane_byte_o` at cycle t+2.
  - The first-arriving lane therefore sees latency 2 + max_arrival.
- Throughput: one word per cycle while all active lanes are valid. No back-pressure.
- `lane_valid_o` drops exactly 2 cycles after the first active lane's tapped valid chain ends.
- `skew_err_o` is never asserted together with `lane_valid_o`.
- Back-to-back packets:
  - A new packet is detected only after DRAIN or ERROR has returned to IDLE.
  - An IDLE cycle that already sees valid high counts as arrival 0.

## Structure
- Shared package `mipi_csi_pkg` holds:
  - the state enum;
  - the lane-code constants `LANES_1`, `LANES_2`, `LANES_4`, `LANES_8`;
  - function `lane_count(code, MIPI_LANES)`, which clamps;
  - constant `SKEW_W = clog2(MAX_SKEW+1)`.
- Sub-module `mipi_rx_lane_delay`, instantiated once per lane:
  - (MAX_SKEW+1)-deep byte+valid shift register;
  - registered tap mux with a `tap_i` input of width SKEW_W;
  - outputs the delayed byte and delayed valid.
- The top level holds the FSM, arrival capture, tap computation and output masking.

## Test plan
- **Zero skew:** MIPI_LANES=4, code 2. All four lanes valid at t=10 with bytes 0x11, 0x22, 0x33, 0x44 incrementing → `lane_valid_o` high at t=12, `lane_byte_o`=0x44332211. Valid falls 2 cycles after the inputs fall.
- **Skew within window:** lanes 0–3 arrive at offsets 0, 2, 1, 3 (MAX_SKEW=4) → taps 3, 1, 2, 0. Output is first valid at t0+5 and the first word contains each lane's first byte.
- **Skew overflow:** lane 3 arrives at offset 5 with MAX_SKEW=4 → `skew_err_o` pulses once. No `lane_valid_o`. Returns to IDLE after all valids drop.
- **Reduced lanes:** MIPI_LANES=4, code 1 (2 lanes), lanes 2–3 toggling randomly → only lanes 0–1 are aligned and bits [31:16] of `lane_byte_o` stay 0.
- **Early drop:** lane 1 drops valid 3 cycles before the others in STREAM → `lane_valid_o` falls 2 cycles after lane 1's tapped drop. DRAIN holds until all valids are low; the next packet aligns normally.
- **Reset mid-stream:** assert `reset_i` for 1 cycle during STREAM → all outputs are 0 on the next cycle. A following packet with zero skew produces output 2 cycles after its first valid.
